// File: rtl/ysyx_22050243_alu_exec.sv
// ysyx_22050243_alu_exec: RV64I execute-stage ALU with valid/ready handshakes.
// Add/compare/logic ops complete in one cycle; shifts iterate SHIFT_STEP bits
// per cycle. Optional macro YSYX_22050243_ALU_ILLEGAL_TRAP_EN raises out_illegal
// for code 4'b1111; when it is undefined out_illegal is held at 0.
module ysyx_22050243_alu_exec #(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_illegal
);

`ifdef YSYX_22050243_ALU_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [3:0]      op_p1;
    logic [XLEN-1:0] sh_val_p1;
    logic [6:0]      sh_rem_p1;

    function automatic logic is_shift_op(input logic [3:0] c);
        case (c)
            4'b0001, 4'b0101, 4'b1101, 4'b1011, 4'b1100, 4'b1110: is_shift_op = 1'b1;
            default:                                              is_shift_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_w_op(input logic [3:0] c);
        case (c)
            4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110: is_w_op = 1'b1;
            default:                                     is_w_op = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        sext32 = {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // W right shifts must start from a properly extended 32-bit value so the
    // 64-bit iteration shifts in the right fill bits.
    function automatic logic [XLEN-1:0] preload(input logic [3:0] c, input logic [XLEN-1:0] a);
        case (c)
            4'b1100: preload = {{(XLEN-32){1'b0}}, a[31:0]};
            4'b1110: preload = sext32(a);
            default: preload = a;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] finalize(input logic [3:0] c, input logic [XLEN-1:0] v);
        finalize = is_w_op(c) ? sext32(v) : v;
    endfunction

    function automatic logic [XLEN-1:0] shift_once(input logic [3:0] c,
                                                   input logic [XLEN-1:0] v,
                                                   input logic [6:0] amt);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        case (c)
            4'b0101, 4'b1100: shift_once = v >> amt;
            4'b1101, 4'b1110: shift_once = $unsigned(sv >>> amt);
            default:          shift_once = v << amt;
        endcase
    endfunction

    // Single-cycle result; shift codes only reach here with a zero shift amount.
    function automatic logic [XLEN-1:0] quick_result(input logic [3:0] c,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (c)
            4'b0000: quick_result = a + b;
            4'b1000: quick_result = a - b;
            4'b0010: quick_result = {{(XLEN-1){1'b0}}, (sa < sb)};
            4'b0011: quick_result = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100: quick_result = a ^ b;
            4'b0110: quick_result = a | b;
            4'b0111: quick_result = a & b;
            4'b1001: quick_result = sext32(a + b);
            4'b1010: quick_result = sext32(a - b);
            4'b0001, 4'b0101, 4'b1101, 4'b1011, 4'b1100, 4'b1110:
                     quick_result = finalize(c, preload(c, a));
            default: quick_result = '0;
        endcase
    endfunction

    logic            accept;
    logic [6:0]      shamt_in;
    logic [6:0]      step;
    logic [6:0]      rem_next;
    logic [XLEN-1:0] shifted;

    // Handshake, shift amount selection and one iteration of the shifter.
    always_comb begin
        in_ready = !flush && (state == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        shamt_in = is_w_op(alu_ctrl) ? {2'b00, src2[4:0]} : {1'b0, src2[5:0]};
        step     = (sh_rem_p1 > STEP) ? STEP : sh_rem_p1;
        rem_next = sh_rem_p1 - step;
        shifted  = shift_once(op_p1, sh_val_p1, step);
    end

    // Control FSM with registered result; reset beats flush beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            result      <= '0;
            op_p1       <= '0;
            sh_val_p1   <= '0;
            sh_rem_p1   <= '0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift_op(alu_ctrl) && (shamt_in != 7'd0)) begin
                            op_p1       <= alu_ctrl;
                            sh_val_p1   <= preload(alu_ctrl, src1);
                            sh_rem_p1   <= shamt_in;
                            state       <= SHIFT;
                            out_valid   <= 1'b0;
                            out_illegal <= 1'b0;
                        end else begin
                            result      <= quick_result(alu_ctrl, src1, src2);
                            out_valid   <= 1'b1;
                            out_illegal <= TRAP_EN && (alu_ctrl == 4'b1111);
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid   <= 1'b0;
                        out_illegal <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh_val_p1 <= shifted;
                    sh_rem_p1 <= rem_next;
                    if (rem_next == 7'd0) begin
                        result    <= finalize(op_p1, shifted);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_alu_exec.sv
// Testbench for ysyx_22050243_alu_exec: directed cases plus randomized ops
// against a one-shot arithmetic reference model.
module tb_ysyx_22050243_alu_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

`ifdef YSYX_22050243_ALU_ILLEGAL_TRAP_EN
    localparam logic EXP_TRAP = 1'b1;
`else
    localparam logic EXP_TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    ysyx_22050243_alu_exec #(.XLEN(64), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_illegal(out_illegal)
    );

    function automatic logic [63:0] sx(input logic [31:0] v);
        sx = {{32{v[31]}}, v};
    endfunction

    function automatic bit is_w(input logic [3:0] c);
        is_w = (c == 4'b1001) || (c == 4'b1010) || (c == 4'b1011) || (c == 4'b1100) || (c == 4'b1110);
    endfunction

    function automatic bit is_sh(input logic [3:0] c);
        is_sh = (c == 4'b0001) || (c == 4'b0101) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b1100) || (c == 4'b1110);
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [31:0] sa32;
        logic [31:0] t;
        logic [5:0] sh6;
        logic [4:0] sh5;
        sa = $signed(a);
        sa32 = $signed(a[31:0]);
        sh6 = b[5:0];
        sh5 = b[4:0];
        t = '0;
        case (c)
            4'b0000: ref_alu = a + b;
            4'b1000: ref_alu = a - b;
            4'b0001: ref_alu = a << sh6;
            4'b0010: ref_alu = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b0011: ref_alu = (a < b) ? 64'd1 : 64'd0;
            4'b0100: ref_alu = a ^ b;
            4'b0101: ref_alu = a >> sh6;
            4'b1101: ref_alu = $unsigned(sa >>> sh6);
            4'b0110: ref_alu = a | b;
            4'b0111: ref_alu = a & b;
            4'b1001: begin t = a[31:0] + b[31:0]; ref_alu = sx(t); end
            4'b1010: begin t = a[31:0] - b[31:0]; ref_alu = sx(t); end
            4'b1011: begin t = a[31:0] << sh5; ref_alu = sx(t); end
            4'b1100: begin t = a[31:0] >> sh5; ref_alu = sx(t); end
            4'b1110: begin t = $unsigned(sa32 >>> sh5); ref_alu = sx(t); end
            default: ref_alu = 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [63:0] b);
        int sh;
        sh = is_w(c) ? int'(b[4:0]) : int'(b[5:0]);
        ref_lat = (is_sh(c) && sh > 0) ? 1 + (sh + 3) / 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction: offer, accept, wait for result, check, pop.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        int lat;
        bit got;
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = c; src1 = a; src2 = b; out_ready = 1'b0;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(c, b)));
        chk({tag, "_res"}, result, ref_alu(c, a, b));
        chk({tag, "_ill"}, 64'(out_illegal), 64'((c == 4'b1111) && EXP_TRAP));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_pop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [3:0] rc;
        logic [63:0] ra, rb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_res", result, 64'd0);
        chk("rst_ill", 64'(out_illegal), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);

        run_op("add_wrap", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("addw_ovf", 4'b1001, 64'h0000_0000_7FFF_FFFF, 64'd1);
        run_op("sra4", 4'b1101, 64'h8000_0000_0000_0000, 64'd4);
        run_op("sll63", 4'b0001, 64'd1, 64'd63);
        run_op("sraw", 4'b1110, 64'h0000_0000_8000_0000, 64'h24);
        run_op("srlw", 4'b1100, 64'h0000_0000_8000_0000, 64'h24);
        run_op("slt", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("sltu", 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("sll0", 4'b0001, 64'h1234_5678_9ABC_DEF0, 64'hC0);
        run_op("sllw0", 4'b1011, 64'h1234_5678_9ABC_DEF0, 64'h20);
        run_op("sub", 4'b1000, 64'd3, 64'd5);
        run_op("illegal", 4'b1111, 64'h55, 64'hAA);

        // Backpressure: result must hold while consumer stalls.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0000; src1 = 64'd5; src2 = 64'd6; out_ready = 1'b0;
        @(posedge clk);
        #1;
        src1 = 64'd1; src2 = 64'd2;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rdy", 64'(in_ready), 64'd0);
            chk("bp_vld", 64'(out_valid), 64'd1);
            chk("bp_res", result, 64'd11);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_pop", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_vld", 64'(out_valid), 64'd1);
        chk("bp_next_res", result, 64'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Flush in the 3rd cycle of sll by 40; an offer during flush is refused.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0001; src1 = 64'd1; src2 = 64'd40;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0000; src1 = 64'd7; src2 = 64'd8;
        #1;
        chk("fl_rdy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_idle", 64'(in_ready), 64'd1);
        repeat (14) begin
            @(negedge clk);
            chk("fl_novld", 64'(out_valid), 64'd0);
        end

        // Randomized ops with operands scrambled after accept.
        for (int i = 0; i < 50; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (($urandom & 3) == 0) ra = {32'h0, 1'b1, 31'($urandom)};
            run_op("rand", rc, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050243_alu_exec.md
Name: ysyx_22050243_alu_exec

Overview:
- Execute-stage ALU that consumes the 4-bit alu_ctrl code produced by ID's ALU control decode, plus two XLEN operands.
- Performs RV64I integer ops, including the W variants.
- Add, compare and logic ops take one cycle; shifts are iterative, SHIFT_STEP bits per cycle.
- valid/ready on both sides, so EXU can stall on LSU/WBU backpressure.

Parameters:
XLEN, 64, datapath width; only 64 supported (W ops hard-coded to 32-bit low half).
SHIFT_STEP, 4, max shift bits per iteration; power of two, 1..32.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
flush  in  1  synchronous kill; drops in-flight op and held result
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid&&in_ready
alu_ctrl  in  4  op code (encoding below)
src1  in  XLEN  operand A
src2  in  XLEN  operand B / shamt source
out_valid  out  1  result held
out_ready  in  1  consumer takes result
result  out  XLEN  registered result
out_illegal  out  1  code 1111 flag (see Optional Feature)

Behaviour:
- alu_ctrl encoding:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
  - 1001 addw, 1010 subw, 1011 sllw, 1100 srlw, 1110 sraw.
  - 1111 and any other code are illegal.
- Reset: state=IDLE; out_valid=0, result=0, out_illegal=0; internal shift count and operand registers 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- States and transitions:
  - IDLE: on accept, a non-shift op, or a shift with effective shamt 0, writes result and sets out_valid next cycle (latency 1), staying in IDLE.
  - IDLE: on accept of a shift with shamt>0, latch the operand and remaining=shamt, then go to SHIFT.
  - SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
  - SHIFT: when remaining reaches 0, write result, set out_valid, return to IDLE.
  - Shift latency = 1 + ceil(shamt/SHIFT_STEP) cycles from the accept edge.
- Shift amount: RV64 ops use src2[5:0]; W ops use src2[4:0]. Upper src2 bits are ignored.
- W operand preload before iterating:
  - srlw: zero-extend src1[31:0].
  - sraw: sign-extend src1[31:0].
  - sllw: src1 unchanged.
  - The final W result is sign-extended from bit 31.
- sra fills with the sign bit; srl and sll fill with 0.
- Arithmetic:
  - add/sub wrap modulo 2^64.
  - addw/subw compute on the low 32 bits, then sign-extend bit 31.
  - slt is signed, sltu unsigned; both give 0 or 1 in bit 0, upper bits 0.
- Output hold: result and out_valid stay stable until out_valid&&out_ready.
  - Same-cycle pop and accept is legal; the new result appears next cycle with no bubble.
  - If popped with no new accept, out_valid clears next cycle; result keeps its last value.
- flush:
  - Priority: rst > flush > all else.
  - Forces IDLE, out_valid=0, out_illegal=0; any in-flight shift is discarded.
  - An in_valid in a flush cycle is not accepted (in_ready forced 0 while flush=1).
- Operands are sampled only at accept; src changes during SHIFT have no effect.

Optional Feature:
- Macro: YSYX_22050243_ALU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal code completes with latency 1, result=0, out_illegal=1 alongside out_valid.
  - out_illegal is cleared with out_valid.
- Undefined:
  - Illegal codes complete with latency 1 and result=0.
  - out_illegal is tied to 0.

Test Plan:
- add 0xFFFF_FFFF_FFFF_FFFF+1 -> result 0, out_valid one cycle after accept. addw 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000.
- sra src1=0x8000_0000_0000_0000, src2=4, SHIFT_STEP=4 -> 0xF800_0000_0000_0000 at accept+2. sll by 63 -> 0x8000_0000_0000_0000 (src1=1) at accept+17.
- sraw src1=0x0000_0000_8000_0000, src2=0x24 (shamt 4) -> 0xFFFF_FFFF_F800_0000. srlw same operands -> 0x0000_0000_0800_0000.
- slt -1,1 -> 1; sltu -1,1 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0. Then raise out_ready with a new add -> pop and accept in the same cycle, next result the following cycle.
- flush on the 3rd cycle of sll by 40 -> next cycle IDLE, out_valid=0, no result. alu_ctrl=1111 -> result 0, out_illegal=1 only with the macro defined.
